umi_tx_buf: RTL and testbench

- Synthesizable UMI transmit-side buffer: accepts UMI packets as separate fields (data/srcaddr/dstaddr/cmd) on a valid/ready handshake.
- Queues packets in a DEPTH-entry FIFO and presents them as a flat switchboard flit (data/dest/last) on a second valid/ready handshake.
- Sits between a UMI initiator/responder and an sb_tx_sim-style switchboard sender, so it is the transmit counterpart of the UMI receive path.
- Provides runtime input-side ready throttling for backpressure stress.

---
 rtl/umi_tx_pkg.sv | 14 +
 rtl/umi_tx_lfsr.sv | 18 +
 rtl/umi_tx_buf.sv | 94 +++++++++
 tb/tb_umi_tx_buf.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_tx_pkg.sv
// Shared constants and helpers for the UMI transmit buffer and its LFSR.
// Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form.
package umi_tx_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [31:0] dest_t;

    function automatic int flit_width(input int dw, input int aw, input int cw);
        return dw + 2 * aw + cw;
    endfunction

endpackage

// File: rtl/umi_tx_lfsr.sv
// 16-bit Galois LFSR, free-running, synchronous active-low reset to LFSR_SEED.
module umi_tx_lfsr
    import umi_tx_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= LFSR_SEED;
        end else begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/umi_tx_buf.sv
// UMI transmit buffer: field-wise UMI packets in, flat switchboard flits out via a DEPTH-entry FIFO.
// Optional statistics outputs (tx_count, max_occupancy) enabled by defining UMI_TX_BUF_STATS_EN.
module umi_tx_buf
    import umi_tx_pkg::*;
#(
    parameter int DW                 = 256,
    parameter int AW                 = 64,
    parameter int CW                 = 32,
    parameter int DEPTH              = 4,
    parameter bit READY_MODE_DEFAULT = 1'b0
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     ready_mode,
    input  logic [DW-1:0]            umi_data,
    input  logic [AW-1:0]            umi_srcaddr,
    input  logic [AW-1:0]            umi_dstaddr,
    input  logic [CW-1:0]            umi_cmd,
    input  logic                     umi_valid,
    output logic                     umi_ready,
    output logic [DW+2*AW+CW-1:0]    sb_data,
    output dest_t                    sb_dest,
    output logic                     sb_last,
    output logic                     sb_valid,
    input  logic                     sb_ready
`ifdef UMI_TX_BUF_STATS_EN
    ,
    output logic [31:0]              tx_count,
    output logic [$clog2(DEPTH):0]   max_occupancy
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = flit_width(DW, AW, CW);

    logic [FW-1:0] mem [DEPTH];
    logic [PW:0]   wptr;
    logic [PW:0]   rptr;
    logic [PW:0]   occupancy;
    logic          empty;
    logic          full;
    logic          mode;
    logic          push;
    logic          pop;
    logic [15:0]   lfsr_state;

    umi_tx_lfsr u_lfsr (
        .clk    (clk),
        .nreset (nreset),
        .state  (lfsr_state)
    );

    assign occupancy = wptr - rptr;
    assign empty     = (wptr == rptr);
    assign full      = (wptr[PW-1:0] == rptr[PW-1:0]) && (wptr[PW] != rptr[PW]);
    assign mode      = ready_mode ^ READY_MODE_DEFAULT;

    // Ready is deliberately not pop-aware when full, and never looks at umi_valid.
    assign umi_ready = nreset && !full && (!mode || lfsr_state[0]);
    assign push      = umi_valid && umi_ready;
    assign pop       = sb_valid && sb_ready;

    assign sb_valid  = !empty;
    assign sb_data   = mem[rptr[PW-1:0]];
    assign sb_dest   = sb_data[AW+CW-1 -: 32];
    assign sb_last   = 1'b1;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[PW-1:0]] <= {umi_data, umi_srcaddr, umi_dstaddr, umi_cmd};
    end

`ifdef UMI_TX_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (!nreset) begin
            tx_count      <= '0;
            max_occupancy <= '0;
        end else begin
            if (pop) tx_count <= tx_count + 32'd1;
            if (occupancy > max_occupancy) max_occupancy <= occupancy;
        end
    end
`endif

endmodule

// File: tb/tb_umi_tx_buf.sv
// Scoreboard bench for umi_tx_buf: queue-based reference model, random and directed stimulus.
// Define UMI_TX_BUF_STATS_EN to also check tx_count and max_occupancy.
module tb_umi_tx_buf;

    localparam int DW    = 256;
    localparam int AW    = 64;
    localparam int CW    = 32;
    localparam int DEPTH = 4;
    localparam int FW    = DW + 2 * AW + CW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [CW-1:0] cmd;
    } pkt_t;

    logic          clk = 1'b0;
    logic          nreset;
    logic          ready_mode;
    logic [DW-1:0] umi_data;
    logic [AW-1:0] umi_srcaddr;
    logic [AW-1:0] umi_dstaddr;
    logic [CW-1:0] umi_cmd;
    logic          umi_valid;
    logic          umi_ready;
    logic [FW-1:0] sb_data;
    logic [31:0]   sb_dest;
    logic          sb_last;
    logic          sb_valid;
    logic          sb_ready;
`ifdef UMI_TX_BUF_STATS_EN
    logic [31:0]   tx_count;
    logic [2:0]    max_occupancy;
`endif

    umi_tx_buf #(.DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH), .READY_MODE_DEFAULT(1'b0)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .ready_mode  (ready_mode),
        .umi_data    (umi_data),
        .umi_srcaddr (umi_srcaddr),
        .umi_dstaddr (umi_dstaddr),
        .umi_cmd     (umi_cmd),
        .umi_valid   (umi_valid),
        .umi_ready   (umi_ready),
        .sb_data     (sb_data),
        .sb_dest     (sb_dest),
        .sb_last     (sb_last),
        .sb_valid    (sb_valid),
        .sb_ready    (sb_ready)
`ifdef UMI_TX_BUF_STATS_EN
        ,
        .tx_count      (tx_count),
        .max_occupancy (max_occupancy)
`endif
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;
    pkt_t exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic pkt_t rand_pkt();
        pkt_t p;
        for (int i = 0; i < DW / 32; i++) p.data[i*32 +: 32] = $urandom;
        p.src = {$urandom, $urandom};
        p.dst = {$urandom, $urandom};
        p.cmd = $urandom;
        return p;
    endfunction

    // Reference side: predicts umi_ready/sb_valid and records accepted packets.
    logic [15:0] lfsr_m;
    logic        rst_prev_low = 1'b0;
    int          max_m = 0;
    always @(negedge clk) begin
        if (!nreset) begin
            chk("ready_in_reset", 64'(umi_ready), 64'd0);
            if (rst_prev_low) chk("valid_in_reset", 64'(sb_valid), 64'd0);
            exp_q.delete();
            lfsr_m       = 16'hACE1;
            max_m        = 0;
            rst_prev_low = 1'b1;
        end else begin
            rst_prev_low = 1'b0;
            chk("umi_ready", 64'(umi_ready),
                64'((exp_q.size() < DEPTH) && (!ready_mode || lfsr_m[0])));
            chk("sb_valid", 64'(sb_valid), 64'(exp_q.size() != 0));
`ifdef UMI_TX_BUF_STATS_EN
            chk("max_occupancy", 64'(max_occupancy), 64'(max_m));
`endif
            if (exp_q.size() > max_m) max_m = exp_q.size();
            if (umi_valid && umi_ready) begin
                exp_q.push_back(pkt_t'({umi_data, umi_srcaddr, umi_dstaddr, umi_cmd}));
                acc_cnt++;
            end
            lfsr_m = lfsr_next(lfsr_m);
        end
    end

    // Monitor: compares every popped flit against the scoreboard head.
    int pops_m = 0;
    always @(negedge clk) begin
        #1;
        if (!nreset) begin
            pops_m = 0;
        end else begin
`ifdef UMI_TX_BUF_STATS_EN
            chk("tx_count", 64'(tx_count), 64'(pops_m));
`endif
            if (sb_valid && sb_ready) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_empty: got sb_valid=1 expected no packet queued");
                end else begin
                    if (sb_data === FW'(exp_q[0])) n_pass++;
                    else $display("FAIL sb_data: got %h expected %h", sb_data, FW'(exp_q[0]));
                    chk("sb_dest", 64'(sb_dest), 64'(exp_q[0].dst[AW-1 -: 32]));
                    chk("sb_last", 64'(sb_last), 64'd1);
                    void'(exp_q.pop_front());
                    pops_m++;
                end
            end
        end
    end

    task automatic drive(input pkt_t p);
        umi_data    = p.data;
        umi_srcaddr = p.src;
        umi_dstaddr = p.dst;
        umi_cmd     = p.cmd;
        umi_valid   = 1'b1;
    endtask

    task automatic wait_accept(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = umi_ready;
            @(posedge clk);
            #1;
        end
        umi_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL accept_timeout: got no acceptance expected within %0d cycles", budget);
        end
    endtask

    task automatic send(input pkt_t p);
        drive(p);
        wait_accept(200);
    endtask

    task automatic wait_empty(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = !sb_valid;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL drain_timeout: got sb_valid=1 expected empty within %0d cycles", budget);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        pkt_t p;
        int   a0;
        int   c0;
        nreset      = 1'b0;
        ready_mode  = 1'b0;
        umi_valid   = 1'b0;
        umi_data    = '0;
        umi_srcaddr = '0;
        umi_dstaddr = '0;
        umi_cmd     = '0;
        sb_ready    = 1'b1;
        idle(3);
        nreset = 1'b1;
        idle(1);

        // First packet: one-cycle latency, dest field and command placement.
        p     = rand_pkt();
        p.cmd = 32'h5;
        p.dst = 64'h1234_5678_0000_0040;
        send(p);
        chk("t1_valid", 64'(sb_valid), 64'd1);
        chk("t1_dest", 64'(sb_dest), 64'h1234_5678);
        chk("t1_cmd", 64'(sb_data[31:0]), 64'h5);
        chk("t1_last", 64'(sb_last), 64'd1);
        idle(2);

        // Fill past capacity with the sink stalled.
        sb_ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) send(rand_pkt());
        drive(rand_pkt());
        idle(3);
        chk("t2_accepted", 64'(acc_cnt - a0), 64'd4);
        chk("t2_ready_full", 64'(umi_ready), 64'd0);
        sb_ready = 1'b1;
        wait_accept(10);
        wait_empty(20);
        chk("t2_total", 64'(acc_cnt - a0), 64'd5);
`ifdef UMI_TX_BUF_STATS_EN
        chk("t2_max_occ", 64'(max_occupancy), 64'd4);
`endif

        // Streaming at one packet per cycle.
        a0 = acc_cnt;
        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            p      = rand_pkt();
            p.data = DW'(i);
            send(p);
        end
        chk("t3_cycles", 64'(cyc - c0), 64'd100);
        chk("t3_accepted", 64'(acc_cnt - a0), 64'd100);
        wait_empty(10);

        // LFSR-gated ready with valid held high.
        ready_mode = 1'b1;
        a0 = acc_cnt;
        for (int i = 0; i < 1000; i++) begin
            drive(rand_pkt());
            sb_ready = ($urandom_range(0, 7) != 0);
            idle(1);
        end
        umi_valid = 1'b0;
        chk("t4_rate_in_range", 64'((acc_cnt - a0) >= 400 && (acc_cnt - a0) <= 600), 64'd1);
        ready_mode = 1'b0;
        sb_ready   = 1'b1;
        wait_empty(20);

        // Reset discards queued packets.
        sb_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_pkt());
        nreset = 1'b0;
        idle(1);
        nreset = 1'b1;
        chk("t5_valid_after_rst", 64'(sb_valid), 64'd0);
        sb_ready = 1'b1;
        send(rand_pkt());
        wait_empty(10);
`ifdef UMI_TX_BUF_STATS_EN
        chk("t5_tx_count", 64'(tx_count), 64'd1);
        chk("t5_max_occ", 64'(max_occupancy), 64'd1);
`endif

        // Random mix of valid, backpressure and mode changes.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) != 0) drive(rand_pkt());
            else umi_valid = 1'b0;
            sb_ready   = ($urandom_range(0, 2) != 0);
            ready_mode = ($urandom_range(0, 9) == 0) ? ~ready_mode : ready_mode;
            idle(1);
        end
        umi_valid  = 1'b0;
        ready_mode = 1'b0;
        sb_ready   = 1'b1;
        wait_empty(20);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
